// File: rtl/reg_file_ba.sv
// General-purpose register file: one write port, two registered read ports with
// BaOut zeroing of R0, optional write-to-read bypass and a one-register-per-cycle clear sweep.
module reg_file_ba #(
    parameter int WIDTH         = 32,
    parameter int NUM_REGS      = 16,
    parameter bit ZERO_R0_ON_BA = 1'b1,
    parameter bit BYPASS        = 1'b1,
    localparam int AW           = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic             ba_out_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    input  logic             ba_out_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             init,
    output logic             busy,
    output logic             wr_drop,
    output logic             state_dbg
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     idx;
    logic [AW-1:0]     idx_nxt;
    logic [WIDTH-1:0]  regs [NUM_REGS];
    logic              waddr_ok;
    logic              we_acc;
    logic [WIDTH-1:0]  rd_nxt_a;
    logic [WIDTH-1:0]  rd_nxt_b;
    logic              last_idx;

    assign waddr_ok  = (32'(waddr) < NUM_REGS);
    assign we_acc    = we && (state == IDLE) && waddr_ok;
    assign last_idx  = (idx == AW'(NUM_REGS - 1));
    assign busy      = (state == SWEEP);
    assign state_dbg = state;

    // Priority: out of range, then BaOut zeroing of R0, then bypass, then stored value.
    function automatic logic [WIDTH-1:0] read_port(
        input logic [AW-1:0]    ra,
        input logic             ba,
        input logic [WIDTH-1:0] stored,
        input logic             acc,
        input logic [AW-1:0]    wa,
        input logic [WIDTH-1:0] wd
    );
        logic [WIDTH-1:0] r;
        r = stored;
        if (32'(ra) >= NUM_REGS) begin
            r = '0;
        end else if (ZERO_R0_ON_BA && (ra == '0) && ba) begin
            r = '0;
        end else if (BYPASS && acc && (wa == ra)) begin
            r = wd;
        end
        return r;
    endfunction

    always_comb begin
        rd_nxt_a = '0;
        rd_nxt_b = '0;
        rd_nxt_a = read_port(raddr_a, ba_out_a, regs[raddr_a], we_acc, waddr, wdata);
        rd_nxt_b = read_port(raddr_b, ba_out_b, regs[raddr_b], we_acc, waddr, wdata);
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (init) begin
                    state_nxt = SWEEP;
                    idx_nxt   = '0;
                end
            end
            SWEEP: begin
                idx_nxt = idx + AW'(1);
                if (last_idx) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // The sweep owns the array while it runs; writes are refused, not queued.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (state == SWEEP) begin
                regs[idx] <= '0;
            end else if (we_acc) begin
                regs[waddr] <= wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rdata_a <= '0;
            rdata_b <= '0;
            wr_drop <= 1'b0;
        end else begin
            rdata_a <= rd_nxt_a;
            rdata_b <= rd_nxt_b;
            wr_drop <= we && (state == SWEEP);
        end
    end

endmodule

// File: tb/tb_reg_file_ba.sv
// Bench for reg_file_ba: two instances (bypass/zeroing on and off) sharing stimulus,
// checked against a vector table and an array-based reference model.
module tb_reg_file_ba;

    localparam int W  = 32;
    localparam int NR = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [W-1:0]  wdata = '0;
    logic [AW-1:0] raddr_a = '0;
    logic          ba_out_a = 1'b0;
    logic [AW-1:0] raddr_b = '0;
    logic          ba_out_b = 1'b0;
    logic          init = 1'b0;

    logic [W-1:0]  rdata_a, rdata_b, nb_rdata_a, nb_rdata_b;
    logic          busy, wr_drop, state_dbg, nb_busy, nb_wr_drop, nb_state_dbg;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [W-1:0] mem [NR];
    logic         m_busy;
    int           m_idx;

    always #5 clk = ~clk;

    reg_file_ba #(.WIDTH(W), .NUM_REGS(NR), .ZERO_R0_ON_BA(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .ba_out_a(ba_out_a), .rdata_a(rdata_a),
        .raddr_b(raddr_b), .ba_out_b(ba_out_b), .rdata_b(rdata_b),
        .init(init), .busy(busy), .wr_drop(wr_drop), .state_dbg(state_dbg)
    );

    reg_file_ba #(.WIDTH(W), .NUM_REGS(NR), .ZERO_R0_ON_BA(1'b0), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .ba_out_a(ba_out_a), .rdata_a(nb_rdata_a),
        .raddr_b(raddr_b), .ba_out_b(ba_out_b), .rdata_b(nb_rdata_b),
        .init(init), .busy(nb_busy), .wr_drop(nb_wr_drop), .state_dbg(nb_state_dbg)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] waddr;
        logic [W-1:0]  wdata;
        logic [AW-1:0] ra;
        logic          ba;
        logic [AW-1:0] rb;
        logic          bb;
        logic [W-1:0]  exp_a;
        logic [W-1:0]  exp_b;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] m_read(input int ra, input logic ba, input bit zero_en,
                                            input bit byp_en, input logic acc, input int wa,
                                            input logic [W-1:0] wd);
        if (ra >= NR) return '0;
        if (zero_en && ra == 0 && ba) return '0;
        if (byp_en && acc && wa == ra) return wd;
        return mem[ra];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NR; i++) mem[i] = '0;
        m_busy = 1'b0;
        m_idx  = 0;
    endtask

    task automatic drive(input logic w, input int wa, input logic [W-1:0] wd, input int ra,
                         input logic ba, input int rb, input logic bb, input logic it);
        we = w; waddr = AW'(wa); wdata = wd;
        raddr_a = AW'(ra); ba_out_a = ba; raddr_b = AW'(rb); ba_out_b = bb; init = it;
    endtask

    // One clock: predict from the model, advance the model, compare after the edge.
    task automatic cycle();
        logic acc;
        logic [W-1:0] ea, eb, na, nb;
        logic ed;
        acc = we && !m_busy;
        ea = m_read(int'(raddr_a), ba_out_a, 1'b1, 1'b1, acc, int'(waddr), wdata);
        eb = m_read(int'(raddr_b), ba_out_b, 1'b1, 1'b1, acc, int'(waddr), wdata);
        na = m_read(int'(raddr_a), ba_out_a, 1'b0, 1'b0, acc, int'(waddr), wdata);
        nb = m_read(int'(raddr_b), ba_out_b, 1'b0, 1'b0, acc, int'(waddr), wdata);
        ed = we && m_busy;
        if (acc) mem[int'(waddr)] = wdata;
        if (m_busy) begin
            mem[m_idx] = '0;
            m_idx++;
            if (m_idx == NR) m_busy = 1'b0;
        end else if (init) begin
            m_busy = 1'b1;
            m_idx  = 0;
        end
        @(posedge clk);
        #1;
        chk("rdata_a", rdata_a, ea);
        chk("rdata_b", rdata_b, eb);
        chk("nb_rdata_a", nb_rdata_a, na);
        chk("nb_rdata_b", nb_rdata_b, nb);
        chk("busy", W'(busy), W'(m_busy));
        chk("wr_drop", W'(wr_drop), W'(ed));
        chk("state_dbg", W'(state_dbg), W'(m_busy));
        chk("nb_busy", W'(nb_busy), W'(m_busy));
        chk("nb_wr_drop", W'(nb_wr_drop), W'(ed));
    endtask

    task automatic async_reset();
        #2;
        clr = 1'b0;
        #1;
        chk("rst_rdata_a", rdata_a, '0);
        chk("rst_rdata_b", rdata_b, '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_wr_drop", W'(wr_drop), '0);
        chk("rst_nb_rdata_a", nb_rdata_a, '0);
        m_reset();
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic count_sweep(input string name);
        int n;
        n = 0;
        drive(1'b0, 0, '0, 0, 1'b0, 0, 1'b0, 1'b1);
        cycle();
        init = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            n++;
            raddr_a = AW'($urandom_range(0, NR - 1));
            raddr_b = AW'($urandom_range(0, NR - 1));
            init = (k == 3);
            cycle();
        end
        chk(name, W'(n), W'(NR));
    endtask

    initial begin
        m_reset();
        vecs[0] = '{1'b1, 4'd5, 32'hDEADBEEF, 4'd0, 1'b0, 4'd0, 1'b0, 32'h0,        32'h0};
        vecs[1] = '{1'b0, 4'd0, 32'h0,        4'd5, 1'b0, 4'd5, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 4'd7, 32'h0000CAFE, 4'd7, 1'b0, 4'd5, 1'b0, 32'h0000CAFE, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 4'd0, 32'h00001234, 4'd0, 1'b1, 4'd0, 1'b0, 32'h0,        32'h00001234};
        vecs[4] = '{1'b0, 4'd0, 32'h0,        4'd0, 1'b1, 4'd0, 1'b0, 32'h0,        32'h00001234};
        vecs[5] = '{1'b0, 4'd0, 32'h0,        4'd3, 1'b1, 4'd7, 1'b1, 32'h0,        32'h0000CAFE};
        vecs[6] = '{1'b1, 4'd3, 32'h00000033, 4'd3, 1'b1, 4'd3, 1'b0, 32'h00000033, 32'h00000033};
        vecs[7] = '{1'b0, 4'd0, 32'h0,        4'd3, 1'b1, 4'd0, 1'b1, 32'h00000033, 32'h0};

        repeat (2) @(negedge clk);
        chk("por_rdata_a", rdata_a, '0);
        chk("por_busy", W'(busy), '0);
        clr = 1'b1;

        // directed vectors: write/read latency, bypass, BaOut zeroing
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].we, int'(vecs[i].waddr), vecs[i].wdata, int'(vecs[i].ra), vecs[i].ba,
                  int'(vecs[i].rb), vecs[i].bb, 1'b0);
            cycle();
            chk($sformatf("vec%0d_a", i), rdata_a, vecs[i].exp_a);
            chk($sformatf("vec%0d_b", i), rdata_b, vecs[i].exp_b);
        end

        // mid-cycle async reset, then every register reads back 0
        async_reset();
        for (int i = 0; i < NR; i++) begin
            drive(1'b0, 0, '0, i, 1'b0, NR - 1 - i, 1'b0, 1'b0);
            cycle();
        end

        // full load, sweep with a dropped write in sweep cycle 4 and init ignored mid-sweep
        for (int i = 0; i < NR; i++) begin
            drive(1'b1, i, $urandom_range(1, 32'h7FFF_FFFF) | 32'h1, i, 1'b0, i, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, 0, '0, 0, 1'b0, 0, 1'b0, 1'b1);
        cycle();
        init = 1'b0;
        for (int k = 1; k <= NR; k++) begin
            we = (k == 4); waddr = 4'd9; wdata = 32'hA5A5A5A5;
            raddr_a = 4'd9; raddr_b = AW'(k - 1); init = (k == 8);
            cycle();
            if (k == 4) chk("drop_pulse", W'(wr_drop), 32'h1);
        end
        we = 1'b0; init = 1'b0;
        chk("sweep_done_busy", W'(busy), '0);
        for (int i = 0; i < NR; i++) begin
            drive(1'b0, 0, '0, i, 1'b0, i, 1'b0, 1'b0);
            cycle();
            chk("post_sweep_zero", rdata_a, '0);
        end

        // same-edge write and init: write lands, sweep then clears it
        drive(1'b1, 12, 32'h0BADF00D, 12, 1'b0, 12, 1'b0, 1'b1);
        cycle();
        drive(1'b0, 0, '0, 12, 1'b0, 12, 1'b0, 1'b0);
        for (int k = 0; k < NR + 2; k++) cycle();

        // reset in sweep cycle 6, then a full restart
        for (int i = 0; i < NR; i++) begin
            drive(1'b1, i, 32'h100 + i, 0, 1'b0, 0, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, 0, '0, 0, 1'b0, 0, 1'b0, 1'b1);
        cycle();
        init = 1'b0;
        for (int k = 0; k < 6; k++) cycle();
        async_reset();
        chk("midsweep_busy", W'(busy), '0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 0, '0, 10 + i, 1'b0, 13 - i, 1'b0, 1'b0);
            cycle();
        end
        count_sweep("restart_len");

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(0, NR - 1), $urandom,
                  $urandom_range(0, NR - 1), 1'($urandom_range(0, 1)),
                  $urandom_range(0, NR - 1), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 24) == 0);
            cycle();
        end
        drive(1'b0, 0, '0, 0, 1'b0, 0, 1'b0, 1'b0);
        for (int k = 0; k < NR + 1; k++) cycle();
        count_sweep("final_sweep_len");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
